fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the dual-clock sample FIFO in the FIR core, running entirely in the read (`clk2`) domain. It drives the FIFO's `rd_en` and tracks the one-cycle registered read latency. It captures `rd_data` into a 3-entry output buffer and presents samples to the FIR datapath on a valid/ready stream, with frame delimiting (`out_last`) every `FRAME_LEN` samples.

## Interface
- `DATA_W`, 16, sample width; matches the FIFO word.
- `FRAME_LEN`, 64, samples per frame (tap count); power of two, ≥2.
- `CNT_W`, 16, width of `sample_cnt`.

Ports:
- `clk2`  in  1  read-domain clock.
- `rd_rstn`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = fetch samples, 0 = stop fetching and drain.
- `fifo_empty`  in  1  registered empty flag from the FIFO.
- `rd_data`  in  DATA_W  FIFO read data; valid the cycle after an accepted read.
- `rd_en`  out  1  FIFO read request (combinational from state and counters).
- `out_data`  out  DATA_W  head-of-buffer sample.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts.
- `out_last`  out  1  qualifies `out_data` as the last sample of a frame.
- `sample_cnt`  out  CNT_W  total accepted output samples; wraps.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Accepted FIFO read at edge N: `rd_en && !fifo_empty` sampled at N. Set `pending` ← 1 for edge N+1, otherwise 0. At N+1, when `pending`=1, capture `rd_data` into the buffer.
- `rd_en` = (state==RUN) && `run` && (occ + pending < 3). `rd_en` may be high while `fifo_empty`=1; no capture follows.
- Output handshake: `out_valid && out_ready` pops the head, increments `sample_cnt`, and advances `frame_idx` (0..FRAME_LEN-1, wraps).
- `out_last` = `out_valid` && `frame_idx`==FRAME_LEN-1.
- Capture and pop in the same cycle: occ unchanged. Capture when occ=3 cannot occur; assert this in simulation.
- FSM:
  - INIT: entered on reset. `rd_en`=0 for 2 cycles, because the FIFO's `fifo_empty` reads 0 for the first cycle after reset. Then go to IDLE.
  - IDLE: `rd_en`=0. Go to RUN when `run`=1.
  - RUN: issue reads. Go to DRAIN when `run`=0.
  - DRAIN: no new reads. An in-flight `pending` is still captured. Go to IDLE when pending=0 and occ=0. If `run` returns to 1 in DRAIN, go straight to RUN.
- `frame_idx` and `sample_cnt` persist across stop/run. They are cleared only by reset.

## Timing
- Reset values: `rd_en`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `sample_cnt`=0, `busy`=1 (INIT). Buffer occ=0, pending=0, `frame_idx`=0.
- Reset asserted mid-operation: all state clears immediately. Buffered and in-flight samples are discarded, and the FSM restarts in INIT.
- Latency: `rd_en` accepted at edge N → `out_valid`=1 after edge N+1 (2 cycles from first issue with an empty buffer).
- Throughput: 1 sample/cycle sustained when the FIFO is non-empty and `out_ready`=1.
- `out_ready`=0: buffer fills to 3, then `rd_en` drops. No sample is lost or duplicated.
- `out_data`, `out_valid`, and `out_last` are stable while `out_valid && !out_ready`.

## Structure
- Shared package `fir_pkg`: `DATA_W`, `FRAME_LEN` default, and the FSM state enum (INIT, IDLE, RUN, DRAIN).
- Sub-module `out_skid_buf`: 3-entry synchronous FIFO with push/pop, occ, and head output. The top level holds the FSM, `pending`, `frame_idx`, and `sample_cnt`.

## Test plan
- Reset, `run`=1 immediately, FIFO empty → `rd_en`=0 for the 2 INIT cycles. No capture, and `out_valid` stays 0.
- FIFO holds 0x0001..0x0004, `out_ready`=1 → `out_data` sequence 0x0001..0x0004 on consecutive cycles, with first `out_valid` 2 cycles after first `rd_en`. `sample_cnt` ends at 4.
- `out_ready`=0 with 6 words queued → exactly 3 captured and `rd_en` drops. Raise `out_ready` → 6 words out in order, none lost.
- Stream 130 samples with `FRAME_LEN`=64 → `out_last` high on sample indices 63 and 127 only.
- Drop `run` while a read is in flight → DRAIN captures that word, emits it, then IDLE (`busy`=0). `rd_en` stays 0 throughout.
- Assert `rd_rstn` low with occ=2 → `out_valid`=0 and `sample_cnt`=0 immediately. After release, INIT holds `rd_en`=0 for 2 cycles.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR-core constants, read-controller FSM states and a mod-3 pointer helper.
package fir_pkg;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 64;
  localparam int CNT_W     = 16;
  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } rd_state_e;

  function automatic logic [1:0] ptr_inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/out_skid_buf.sv
// Three-entry output FIFO; head is combinational (zero-latency pop), push lands next cycle.
// Push and pop together keep occupancy; the caller never pushes when full.
module out_skid_buf
  import fir_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_pop   = pop && (occ_q != 2'd0);
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc3(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc3(rd_ptr_q);
    end
    case ({push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Head forced to zero when empty so out_data is clean while out_valid is low.
  assign occ  = occ_q;
  assign head = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: issues rd_en, captures rd_data one cycle later into a 3-deep buffer, emits framed valid/ready samples.
// Accepted read at edge N gives out_valid after edge N+1; with out_ready low the buffer fills to 3 and reads stop.
module fifo_rd_ctrl #(
  parameter int DATA_W    = fir_pkg::DATA_W,
  parameter int FRAME_LEN = fir_pkg::FRAME_LEN,
  parameter int CNT_W     = fir_pkg::CNT_W
) (
  input  logic              clk2,
  input  logic              rd_rstn,
  input  logic              run,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              busy
);
  localparam int FW = $clog2(FRAME_LEN);
  typedef fir_pkg::rd_state_e state_e;

  state_e           state_q, state_d;
  logic             init_cnt_q, init_cnt_d;
  logic             pending_q, pending_d;
  logic [FW-1:0]    frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [1:0]       occ;
  logic             pop;

  out_skid_buf #(.W(DATA_W)) u_buf (
    .clk      (clk2),
    .rst_n    (rd_rstn),
    .push     (pending_q),
    .push_dat (rd_data),
    .pop      (pop),
    .occ      (occ),
    .head     (out_data)
  );

  assign out_valid  = (occ != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_last   = out_valid && (frame_idx_q == FW'(FRAME_LEN - 1));
  assign sample_cnt = sample_cnt_q;
  assign busy       = (state_q != fir_pkg::ST_IDLE);
  // Count the in-flight read as a reserved slot so a capture never finds the buffer full.
  assign rd_en = (state_q == fir_pkg::ST_RUN) && run &&
                 (({1'b0, occ} + {2'b00, pending_q}) < 3'(fir_pkg::BUF_DEPTH));

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    pending_d    = rd_en && !fifo_empty;
    frame_idx_d  = pop ? frame_idx_q + FW'(1) : frame_idx_q;
    sample_cnt_d = pop ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
    case (state_q)
      fir_pkg::ST_INIT: begin
        init_cnt_d = 1'b1;
        if (init_cnt_q) state_d = fir_pkg::ST_IDLE;
      end
      fir_pkg::ST_IDLE: if (run) state_d = fir_pkg::ST_RUN;
      fir_pkg::ST_RUN:  if (!run) state_d = fir_pkg::ST_DRAIN;
      fir_pkg::ST_DRAIN: begin
        if (run) state_d = fir_pkg::ST_RUN;
        else if (!pending_q && (occ == 2'd0)) state_d = fir_pkg::ST_IDLE;
      end
      default: state_d = fir_pkg::ST_INIT;
    endcase
  end

  always_ff @(posedge clk2 or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state_q      <= fir_pkg::ST_INIT;
      init_cnt_q   <= 1'b0;
      pending_q    <= 1'b0;
      frame_idx_q  <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      pending_q    <= pending_d;
      frame_idx_q  <= frame_idx_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assert property (@(posedge clk2) disable iff (!rd_rstn) !(pending_q && (occ == 2'd3)));
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a queue-backed FIFO source with registered empty flag, and an
// expected in-order sample stream with frame position and running count derived from the sample index.
module tb_fifo_rd_ctrl;
  localparam int DW = 16;
  localparam int FL = 64;
  localparam int CW = 16;

  logic          clk2 = 1'b0;
  logic          rd_rstn = 1'b1;
  logic          run = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [CW-1:0] sample_cnt;
  logic          busy;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got_dat[$];
  logic          got_last[$];
  int            got_cnt[$];
  int            got_cyc[$];
  int            cyc = 0, n_rd = 0, first_rd = -1, first_vld = -1, stall_bad = 0, max_infl = 0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  always #5 clk2 = ~clk2;

  fifo_rd_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk2       (clk2),
    .rd_rstn    (rd_rstn),
    .run        (run),
    .fifo_empty (fifo_empty),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .sample_cnt (sample_cnt),
    .busy       (busy)
  );

  // Source FIFO: registered data and empty flag; empty wrongly reads 0 during and just after reset.
  always @(posedge clk2 or negedge rd_rstn) begin
    if (!rd_rstn) begin
      fifo_empty <= 1'b0;
    end else begin
      if (rd_en && !fifo_empty && fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Observer: logs accepted reads and accepted output samples, and stall stability.
  always @(negedge clk2) begin
    cyc++;
    if (!rd_rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en && !fifo_empty) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_dat || out_last !== prev_last))
        stall_bad++;
      if (out_valid && out_ready) begin
        got_dat.push_back(out_data);
        got_last.push_back(out_last);
        got_cnt.push_back(int'(sample_cnt));
        got_cyc.push_back(cyc);
      end
      if (n_rd - got_dat.size() > max_infl) max_infl = n_rd - got_dat.size();
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic clear_logs();
    n_rd = 0; first_rd = -1; first_vld = -1; stall_bad = 0; max_infl = 0;
    got_dat.delete(); got_last.delete(); got_cnt.delete(); got_cyc.delete();
  endtask

  task automatic test_reset();
    logic exp_busy, exp_rd;
    run = 1'b1; out_ready = 1'b1;
    rd_rstn = 1'b0; fifo_q.delete();
    #2;
    total++;
    if (rd_en !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        sample_cnt !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_vals: rd_en=%b vld=%b dat=%h last=%b cnt=%0d busy=%b, need 0 0 0000 0 0 1",
               rd_en, out_valid, out_data, out_last, sample_cnt, busy);
    end
    tick(); tick();
    rd_rstn = 1'b1;
    clear_logs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk2); #1;
      exp_busy = (c != 2);
      exp_rd   = (c == 3);
      total++;
      if (busy !== exp_busy || rd_en !== exp_rd) begin
        bad++;
        $display("FAIL init_seq cycle %0d: busy=%b rd_en=%b, need busy=%b rd_en=%b", c, busy, rd_en, exp_busy, exp_rd);
      end
    end
    total++;
    if (n_rd != 0 || first_vld >= 0) begin
      bad++;
      $display("FAIL init_no_capture: reads=%0d first_vld=%0d, need 0 and -1", n_rd, first_vld);
    end
  endtask

  task automatic test_basic();
    clear_logs(); out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
    for (int c = 0; c < 30 && got_dat.size() < 4; c++) tick();
    total++;
    if (got_dat.size() != 4) begin
      bad++;
      $display("FAIL basic_count: got %0d samples, need 4", got_dat.size());
    end
    for (int i = 0; i < got_dat.size() && i < 4; i++) begin
      total++;
      if (got_dat[i] !== DW'(i + 1) || got_cyc[i] != first_vld + i || got_last[i] !== 1'b0 || got_cnt[i] != i) begin
        bad++;
        $display("FAIL basic_sample %0d: dat=%h cyc=%0d last=%b cnt=%0d, need %h %0d 0 %0d",
                 i, got_dat[i], got_cyc[i], got_last[i], got_cnt[i], DW'(i + 1), first_vld + i, i);
      end
    end
    total++;
    if (first_vld - first_rd != 2) begin
      bad++;
      $display("FAIL basic_latency: %0d cycles from first accepted read to valid, need 2", first_vld - first_rd);
    end
    tick(); tick();
    total++;
    if (sample_cnt !== CW'(4)) begin
      bad++;
      $display("FAIL basic_cnt: sample_cnt=%0d, need 4", sample_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[6];
    clear_logs(); out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      fifo_q.push_back(w[i]);
    end
    repeat (12) tick();
    total++;
    if (n_rd != 3 || got_dat.size() != 0 || rd_en !== 1'b0 || out_valid !== 1'b1 ||
        out_data !== w[0] || fifo_q.size() != 3) begin
      bad++;
      $display("FAIL bp_fill: reads=%0d outs=%0d rd_en=%b vld=%b dat=%h left=%0d, need 3 0 0 1 %h 3",
               n_rd, got_dat.size(), rd_en, out_valid, out_data, fifo_q.size(), w[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got_dat.size() < 6; c++) tick();
    total++;
    if (got_dat.size() != 6) begin
      bad++;
      $display("FAIL bp_count: got %0d samples, need 6", got_dat.size());
    end
    for (int i = 0; i < got_dat.size() && i < 6; i++) begin
      total++;
      if (got_dat[i] !== w[i] || got_cnt[i] != 4 + i) begin
        bad++;
        $display("FAIL bp_sample %0d: dat=%h cnt=%0d, need %h %0d", i, got_dat[i], got_cnt[i], w[i], 4 + i);
      end
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL bp_stall_stable: %0d unstable stall cycles, need 0", stall_bad);
    end
  endtask

  task automatic test_frames();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v;
    logic          exp_last;
    int            n_push, n_last;
    rd_rstn = 1'b0; fifo_q.delete();
    tick(); tick();
    rd_rstn = 1'b1; run = 1'b1;
    repeat (4) tick();
    clear_logs();
    n_push = 0;
    for (int c = 0; c < 3000 && got_dat.size() < 130; c++) begin
      if (n_push < 130 && $urandom_range(0, 3) != 0) begin
        v = DW'($urandom);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        n_push++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    total++;
    if (got_dat.size() != 130) begin
      bad++;
      $display("FAIL frames_count: got %0d samples, need 130", got_dat.size());
    end
    n_last = 0;
    for (int i = 0; i < got_dat.size() && i < exp_q.size(); i++) begin
      exp_last = ((i % FL) == FL - 1);
      if (got_last[i]) n_last++;
      total++;
      if (got_dat[i] !== exp_q[i] || got_last[i] !== exp_last || got_cnt[i] != i) begin
        bad++;
        $display("FAIL frames_sample %0d: dat=%h last=%b cnt=%0d, need %h %b %0d",
                 i, got_dat[i], got_last[i], got_cnt[i], exp_q[i], exp_last, i);
      end
    end
    total++;
    if (n_last != 2) begin
      bad++;
      $display("FAIL frames_nlast: %0d last markers, need 2", n_last);
    end
    total++;
    if (max_infl > 3 || stall_bad != 0) begin
      bad++;
      $display("FAIL frames_occupancy: max outstanding=%0d unstable stalls=%0d, need <=3 and 0", max_infl, stall_bad);
    end
    tick();
    total++;
    if (sample_cnt !== CW'(130)) begin
      bad++;
      $display("FAIL frames_cnt: sample_cnt=%0d, need 130", sample_cnt);
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] v, v2;
    logic          rd_seen;
    clear_logs(); out_ready = 1'b1; run = 1'b1;
    v = DW'($urandom); v2 = DW'($urandom);
    fifo_q.push_back(v);
    for (int k = 0; k < 10 && n_rd == 0; k++) tick();
    total++;
    if (n_rd != 1) begin
      bad++;
      $display("FAIL drain_issue: %0d reads before drop, need 1", n_rd);
    end
    run = 1'b0;
    fifo_q.push_back(v2);
    rd_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk2); #1;
      if (rd_en) rd_seen = 1'b1;
    end
    total++;
    if (rd_seen !== 1'b0 || n_rd != 1 || fifo_q.size() != 1) begin
      bad++;
      $display("FAIL drain_no_reads: rd_en_seen=%b reads=%0d left=%0d, need 0 1 1", rd_seen, n_rd, fifo_q.size());
    end
    total++;
    if (got_dat.size() != 1 || (got_dat.size() == 1 && got_dat[0] !== v)) begin
      bad++;
      $display("FAIL drain_word: got %0d samples (first %h), need 1 sample %h", got_dat.size(),
               (got_dat.size() > 0) ? got_dat[0] : '0, v);
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sample_cnt !== CW'(131)) begin
      bad++;
      $display("FAIL drain_idle: busy=%b vld=%b cnt=%0d, need 0 0 131", busy, out_valid, sample_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] nw[3];
    clear_logs(); fifo_q.delete();
    out_ready = 1'b0; run = 1'b1;
    fifo_q.push_back(DW'($urandom)); fifo_q.push_back(DW'($urandom));
    repeat (8) tick();
    total++;
    if (n_rd != 2 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_setup: reads=%0d vld=%b, need 2 1", n_rd, out_valid);
    end
    rd_rstn = 1'b0; fifo_q.delete();
    #1;
    total++;
    if (out_valid !== 1'b0 || sample_cnt !== '0 || rd_en !== 1'b0 || busy !== 1'b1 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rmid_clear: vld=%b cnt=%0d rd_en=%b busy=%b last=%b, need 0 0 0 1 0",
               out_valid, sample_cnt, rd_en, busy, out_last);
    end
    tick();
    rd_rstn = 1'b1; out_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      nw[i] = DW'($urandom);
      fifo_q.push_back(nw[i]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk2); #1;
      total++;
      if (rd_en !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL rmid_init cycle %0d: rd_en=%b busy=%b, need 0 1", c, rd_en, busy);
      end
    end
    for (int c = 0; c < 30 && got_dat.size() < 3; c++) tick();
    total++;
    if (got_dat.size() != 3) begin
      bad++;
      $display("FAIL rmid_count: got %0d samples, need 3", got_dat.size());
    end
    for (int i = 0; i < got_dat.size() && i < 3; i++) begin
      total++;
      if (got_dat[i] !== nw[i] || got_cnt[i] != i) begin
        bad++;
        $display("FAIL rmid_sample %0d: dat=%h cnt=%0d, need %h %0d", i, got_dat[i], got_cnt[i], nw[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frames();
    test_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
